// File: rtl/sram_mem_stage_pkg.sv
// Shared types and widths for the SRAM-backed memory-stage controller.
package sram_mem_stage_pkg;

    localparam int HALF_W = 16;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one SRAM half access; tc marks the last cycle.
import sram_mem_stage_pkg::*;

module sram_wait_counter (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WCNT_W-1:0] load_value,
    output logic              tc
);

    logic [WCNT_W-1:0] count;

    // Counts down to zero and rests there until the next state entry reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sram_mem_stage_ctrl.sv
// Memory-stage controller: one 32-bit load/store becomes two 16-bit SRAM accesses.
// Optional feature: define SRAM_MEM_STAGE_POSTED_WRITE_EN for posted (non-freezing) stores.
import sram_mem_stage_pkg::*;

module sram_mem_stage_ctrl #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [HALF_W-1:0]  sram_dq_o,
    input  logic [HALF_W-1:0]  sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam logic [WCNT_W-1:0] RELOAD = WCNT_W'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic               req;
    logic               can_accept;
    logic               stall_on_req;
    logic               accept;
    logic               cnt_load;
    logic               tc;
    logic               busy;
    logic               write_q;
    logic [SRAM_AW-2:0] word_q;
    logic [SRAM_AW-2:0] word_next;
    logic [31:0]        wdata_q;

    assign req       = mem_r_en | mem_w_en;
    assign word_next = (SRAM_AW-1)'((addr - 32'(BASE_ADDR)) >> 2);

`ifdef SRAM_MEM_STAGE_POSTED_WRITE_EN
    // The DONE cycle closing a posted store acts like IDLE so the waiting instruction is taken there.
    assign can_accept   = (state == IDLE) || (state == DONE && write_q);
    assign stall_on_req = req && !mem_w_en;
`else
    assign can_accept   = (state == IDLE);
    assign stall_on_req = req;
`endif

    assign accept = can_accept && req;
    assign busy   = (state == LO) || (state == HI);
    assign ready  = can_accept ? !stall_on_req : (state == DONE);

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (RELOAD),
        .tc         (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    state_next = LO;
                    cnt_load   = 1'b1;
                end
            end
            LO: begin
                if (tc) begin
                    state_next = HI;
                    cnt_load   = 1'b1;
                end
            end
            HI: begin
                if (tc) begin
                    state_next = DONE;
                end
            end
        endcase
    end

    // Simultaneous enables are latched as a write, so rdata is left alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            word_q  <= word_next;
            wdata_q <= wdata;
            write_q <= mem_w_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (!write_q && tc) begin
            if (state == LO) begin
                rdata[15:0] <= sram_dq_i;
            end else if (state == HI) begin
                rdata[31:16] <= sram_dq_i;
            end
        end
    end

    // Strobes derive from reset-cleared state, so an async reset releases the bus with no clock.
    assign sram_addr  = {word_q, state == HI};
    assign sram_dq_o  = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign sram_dq_oe = busy && write_q;
    assign sram_we_n  = !(busy && write_q && !tc);
    assign sram_oe_n  = !(busy && !write_q);

endmodule
